read_stream: RTL and testbench

READ_STREAM -- requirements
Module: read_stream

---
 rtl/read_stream_pkg.sv | 17 +
 rtl/read_stream_fifo.sv | 50 +++++
 rtl/read_stream.sv | 163 ++++++++++++++++
 tb/tb_read_stream.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/read_stream_pkg.sv
// Shared types and sizing helpers for the read_stream BRAM reader and its output FIFO.
package read_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam int unsigned DEFAULT_FIFO_DEPTH = 8;

    // Bits needed to count 0..depth words (FIFO occupancy or reads in flight).
    function automatic int unsigned credit_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/read_stream_fifo.sv
// Show-ahead output FIFO with occupancy count; a full FIFO accepts a write when popped in the same cycle.
module read_stream_fifo
    import read_stream_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
    localparam int unsigned CW = credit_width(FIFO_DEPTH),
    localparam int unsigned AW = $clog2(FIFO_DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  empty_o,
    output logic [CW-1:0]         count_o
);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         count_q;
    logic                  full, do_wr, do_rd;

    assign empty_o   = (count_q == '0);
    assign full      = (count_q == CW'(FIFO_DEPTH));
    assign do_rd     = rd_en_i && !empty_o;
    assign do_wr     = wr_en_i && (!full || do_rd);
    assign rd_data_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_wr && !do_rd) count_q <= count_q + 1'b1;
            else if (do_rd && !do_wr) count_q <= count_q - 1'b1;
        end
    end

    // Storage carries no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk_i) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/read_stream.sv
// Strided multi-iteration BRAM reader: issues credit-limited read requests and streams results through a FIFO.
module read_stream
    import read_stream_pkg::*;
#(
    parameter int unsigned DATA_WIDTH             = 8,
    parameter int unsigned LOG_MAX_ITERS          = 16,
    parameter int unsigned LOG_MAX_READS_PER_ITER = 16,
    parameter int unsigned LOG_MAX_ADDRESS        = 16,
    parameter int unsigned FIFO_DEPTH             = DEFAULT_FIFO_DEPTH,
    parameter int unsigned BRAM_LATENCY           = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              configure,
    input  logic [LOG_MAX_ITERS-1:0]          num_iters,
    input  logic [LOG_MAX_READS_PER_ITER-1:0] num_reads_per_iter,
    input  logic [LOG_MAX_ADDRESS-1:0]        base_address,
    input  logic [LOG_MAX_ADDRESS-1:0]        stride,
    output logic [LOG_MAX_ADDRESS-1:0]        address_out,
    output logic                              request,
    input  logic                              valid_in,
    input  logic [DATA_WIDTH-1:0]             data_in,
    input  logic                              avail_in,
    output logic                              valid_out,
    output logic [DATA_WIDTH-1:0]             data_out,
    output logic                              busy,
    output logic                              done
);

    localparam int unsigned CW = credit_width(FIFO_DEPTH);
    localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("read_stream: FIFO_DEPTH must be a power of two and at least 2");
    end
    if (BRAM_LATENCY < 1 || BRAM_LATENCY > 4) begin : g_bad_latency
        $error("read_stream: BRAM_LATENCY must lie in 1..4");
    end

    state_e                            state_q, state_d;
    logic [LOG_MAX_ITERS-1:0]          iters_q, iters_d;
    logic [LOG_MAX_READS_PER_ITER-1:0] reads_q, reads_d, reads_cfg_q, reads_cfg_d;
    logic [LOG_MAX_ADDRESS-1:0]        addr_q, addr_d, base_q, base_d, stride_q, stride_d;
    logic [CW-1:0]                     inflight_q, inflight_d;
    logic                              busy_q, busy_d, done_q, done_d;

    logic [CW-1:0]         fifo_count;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_head;
    logic                  accept, issue, bram_wr, pop;

    // A request is only allowed when a FIFO slot is guaranteed for its data.
    assign accept  = configure && !busy_q;
    assign issue   = (state_q == ST_READ) && (({1'b0, fifo_count} + {1'b0, inflight_q}) < DEPTH_C);
    assign bram_wr = valid_in && (inflight_q != '0);
    assign pop     = !fifo_empty && avail_in;

    always_comb begin
        inflight_d = inflight_q;
        if (issue && !bram_wr) inflight_d = inflight_q + 1'b1;
        else if (bram_wr && !issue) inflight_d = inflight_q - 1'b1;
    end

    always_comb begin
        state_d     = state_q;
        iters_d     = iters_q;
        reads_d     = reads_q;
        reads_cfg_d = reads_cfg_q;
        addr_d      = addr_q;
        base_d      = base_q;
        stride_d    = stride_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    iters_d     = num_iters;
                    reads_d     = num_reads_per_iter;
                    reads_cfg_d = num_reads_per_iter;
                    addr_d      = base_address;
                    base_d      = base_address;
                    stride_d    = stride;
                    if (num_iters == '0 || num_reads_per_iter == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_READ;
                        busy_d  = 1'b1;
                    end
                end
            end
            ST_READ: begin
                if (issue) begin
                    if (reads_q == LOG_MAX_READS_PER_ITER'(1)) begin
                        addr_d  = base_q;
                        reads_d = reads_cfg_q;
                        iters_d = iters_q - 1'b1;
                        if (iters_q == LOG_MAX_ITERS'(1)) state_d = ST_DRAIN;
                    end else begin
                        addr_d  = addr_q + stride_q;
                        reads_d = reads_q - 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                // Finish on the cycle the last word leaves, so done follows it directly.
                if (inflight_q == '0 && (fifo_empty || (fifo_count == CW'(1) && pop))) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            iters_q    <= '0;
            reads_q    <= '0;
            addr_q     <= '0;
            inflight_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            iters_q    <= iters_d;
            reads_q    <= reads_d;
            addr_q     <= addr_d;
            inflight_q <= inflight_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        reads_cfg_q <= reads_cfg_d;
        base_q      <= base_d;
        stride_q    <= stride_d;
    end

    read_stream_fifo #(
        .DATA_WIDTH(DATA_WIDTH),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_i    (clk),
        .rst_ni   (rst),
        .wr_en_i  (bram_wr),
        .wr_data_i(data_in),
        .rd_en_i  (pop),
        .rd_data_o(fifo_head),
        .empty_o  (fifo_empty),
        .count_o  (fifo_count)
    );

    assign address_out = addr_q;
    assign request     = issue;
    assign valid_out   = !fifo_empty;
    assign data_out    = fifo_empty ? '0 : fifo_head;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_read_stream.sv
// Directed bench for read_stream: BRAM model with variable latency, address/data scoreboard queues.
module tb_read_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        configure;
    logic [15:0] num_iters, num_reads_per_iter, base_address, stride;
    logic [15:0] address_out;
    logic        request, valid_in, avail_in, valid_out, busy, done;
    logic [7:0]  data_in, data_out;

    always #5 clk = ~clk;

    read_stream #(
        .DATA_WIDTH(8), .LOG_MAX_ITERS(16), .LOG_MAX_READS_PER_ITER(16),
        .LOG_MAX_ADDRESS(16), .FIFO_DEPTH(4), .BRAM_LATENCY(3)
    ) dut (
        .clk(clk), .rst(rst), .configure(configure), .num_iters(num_iters),
        .num_reads_per_iter(num_reads_per_iter), .base_address(base_address), .stride(stride),
        .address_out(address_out), .request(request), .valid_in(valid_in), .data_in(data_in),
        .avail_in(avail_in), .valid_out(valid_out), .data_out(data_out), .busy(busy), .done(done)
    );

    int total = 0, bad = 0, cyc = 0, lat = 1;
    int req_cnt, out_cnt, done_cnt, first_req_cyc, last_req_cyc, first_vout_cyc;
    int first_out_cyc, last_out_cyc, done_cyc;
    bit seen_vout, toggle_en;
    logic        pv [5];
    logic [15:0] pa [5];
    logic [15:0] exp_addr_q [$];
    logic [7:0]  exp_data_q [$];

    function automatic logic [7:0] mem_word(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        req_cnt = 0; out_cnt = 0; done_cnt = 0; seen_vout = 0;
        first_req_cyc = 0; last_req_cyc = 0; first_vout_cyc = 0;
        first_out_cyc = 0; last_out_cyc = 0; done_cyc = 0;
    endtask

    // Mid-cycle monitor and BRAM model; DUT outputs are stable here.
    task automatic sample();
        if (request) begin
            if (req_cnt == 0) first_req_cyc = cyc;
            last_req_cyc = cyc;
            req_cnt++;
            check("req_expected", 32'(exp_addr_q.size() != 0), 32'd1);
            if (exp_addr_q.size() != 0) check("req_addr", 32'(address_out), 32'(exp_addr_q.pop_front()));
            exp_data_q.push_back(mem_word(address_out));
        end
        if (valid_out && !seen_vout) begin
            seen_vout = 1;
            first_vout_cyc = cyc;
        end
        if (valid_out && avail_in) begin
            if (out_cnt == 0) first_out_cyc = cyc;
            last_out_cyc = cyc;
            out_cnt++;
            check("out_expected", 32'(exp_data_q.size() != 0), 32'd1);
            if (exp_data_q.size() != 0) check("out_data", 32'(data_out), 32'(exp_data_q.pop_front()));
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        for (int k = 4; k > 0; k--) begin
            pv[k] = pv[k-1];
            pa[k] = pa[k-1];
        end
        pv[0] = request;
        pa[0] = address_out;
        valid_in = pv[lat];
        data_in  = mem_word(pa[lat]);
    endtask

    task automatic step();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        cyc++;
        if (toggle_en) avail_in = ~avail_in;
    endtask

    task automatic push_job(input logic [15:0] b, input logic [15:0] s, input int it, input int rd);
        for (int i = 0; i < it; i++)
            for (int j = 0; j < rd; j++)
                exp_addr_q.push_back(16'(b + 16'(j) * s));
    endtask

    task automatic start_job(input logic [15:0] b, input logic [15:0] s, input logic [15:0] it,
                             input logic [15:0] rd);
        base_address = b; stride = s; num_iters = it; num_reads_per_iter = rd;
        configure = 1'b1;
        step();
        configure = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max_cyc);
        int n = 0;
        int d0 = done_cnt;
        while (done_cnt == d0 && n < max_cyc) begin
            step();
            n++;
        end
        check(tag, 32'(done_cnt - d0), 32'd1);
    endtask

    initial begin
        for (int k = 0; k < 5; k++) begin
            pv[k] = 1'b0;
            pa[k] = '0;
        end
        rst = 1'b0; configure = 1'b0; avail_in = 1'b1; toggle_en = 0;
        valid_in = 1'b0; data_in = '0;
        num_iters = '0; num_reads_per_iter = '0; base_address = '0; stride = '0;
        clear_stats();
        step();
        step();
        check("rst_request", 32'(request), 32'd0);
        check("rst_valid_out", 32'(valid_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_address", 32'(address_out), 32'd0);
        check("rst_data_out", 32'(data_out), 32'd0);
        rst = 1'b1;
        step();

        // Basic burst: four consecutive addresses, back-to-back outputs.
        clear_stats(); lat = 1;
        push_job(16'h0010, 16'd1, 1, 4);
        start_job(16'h0010, 16'd1, 16'd1, 16'd4);
        check("t1_busy", 32'(busy), 32'd1);
        wait_done("t1_done", 40);
        check("t1_reqs", 32'(req_cnt), 32'd4);
        check("t1_outs", 32'(out_cnt), 32'd4);
        check("t1_req_span", 32'(last_req_cyc - first_req_cyc), 32'd3);
        check("t1_out_span", 32'(last_out_cyc - first_out_cyc), 32'd3);
        check("t1_first_latency", 32'(first_vout_cyc - first_req_cyc), 32'd2);
        check("t1_done_timing", 32'(done_cyc - last_out_cyc), 32'd1);
        step();
        step();
        check("t1_done_pulses", 32'(done_cnt), 32'd1);
        check("t1_busy_low", 32'(busy), 32'd0);

        // Address wrap across iterations.
        clear_stats();
        push_job(16'hFFFE, 16'd2, 2, 3);
        start_job(16'hFFFE, 16'd2, 16'd2, 16'd3);
        wait_done("t2_done", 60);
        check("t2_reqs", 32'(req_cnt), 32'd6);
        check("t2_outs", 32'(out_cnt), 32'd6);
        check("t2_addr_left", 32'(exp_addr_q.size()), 32'd0);

        // Credit limit with a stalled consumer.
        clear_stats(); lat = 3; avail_in = 1'b0;
        push_job(16'h0040, 16'd1, 1, 10);
        start_job(16'h0040, 16'd1, 16'd1, 16'd10);
        repeat (20) step();
        check("t3_reqs_stalled", 32'(req_cnt), 32'd4);
        check("t3_valid_out", 32'(valid_out), 32'd1);
        check("t3_busy", 32'(busy), 32'd1);
        check("t3_no_outs", 32'(out_cnt), 32'd0);
        avail_in = 1'b1;
        wait_done("t3_done", 100);
        check("t3_reqs", 32'(req_cnt), 32'd10);
        check("t3_outs", 32'(out_cnt), 32'd10);
        check("t3_data_left", 32'(exp_data_q.size()), 32'd0);

        // Zero iterations, then configure while busy.
        clear_stats(); lat = 1;
        start_job(16'h0055, 16'd1, 16'd0, 16'd5);
        check("t4_zero_done", 32'(done), 32'd1);
        check("t4_zero_busy", 32'(busy), 32'd0);
        step();
        check("t4_zero_done_pulse", 32'(done), 32'd0);
        check("t4_zero_reqs", 32'(req_cnt), 32'd0);
        clear_stats();
        push_job(16'h0020, 16'd4, 2, 3);
        start_job(16'h0020, 16'd4, 16'd2, 16'd3);
        step();
        start_job(16'h0080, 16'd1, 16'd1, 16'd1);
        check("t4_busy_kept", 32'(busy), 32'd1);
        wait_done("t4_done", 60);
        check("t4_reqs", 32'(req_cnt), 32'd6);
        check("t4_outs", 32'(out_cnt), 32'd6);
        step();
        step();
        check("t4_done_pulses", 32'(done_cnt), 32'd1);

        // Consumer toggling every cycle.
        clear_stats(); lat = 2; avail_in = 1'b1; toggle_en = 1;
        push_job(16'h0100, 16'd3, 3, 5);
        start_job(16'h0100, 16'd3, 16'd3, 16'd5);
        wait_done("t5_done", 200);
        toggle_en = 0; avail_in = 1'b1;
        check("t5_reqs", 32'(req_cnt), 32'd15);
        check("t5_outs", 32'(out_cnt), 32'd15);
        check("t5_first_latency", 32'(first_vout_cyc - first_req_cyc), 32'd3);
        check("t5_data_left", 32'(exp_data_q.size()), 32'd0);

        // Asynchronous reset with two reads in flight.
        step();
        clear_stats(); lat = 3;
        push_job(16'h0200, 16'd1, 1, 8);
        start_job(16'h0200, 16'd1, 16'd1, 16'd8);
        for (int n = 0; n < 10 && req_cnt == 0; n++) step();
        check("t6_started", 32'(req_cnt > 0), 32'd1);
        step();
        #1 rst = 1'b0;
        #1;
        check("t6_rst_request", 32'(request), 32'd0);
        check("t6_rst_valid_out", 32'(valid_out), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_done", 32'(done), 32'd0);
        check("t6_rst_address", 32'(address_out), 32'd0);
        check("t6_rst_data_out", 32'(data_out), 32'd0);
        exp_addr_q.delete();
        exp_data_q.delete();
        step();
        rst = 1'b1;
        clear_stats();
        repeat (6) step();
        check("t6_late_ignored", 32'(valid_out), 32'd0);
        check("t6_no_outs", 32'(out_cnt), 32'd0);
        check("t6_idle", 32'(busy), 32'd0);
        lat = 1;
        push_job(16'h0030, 16'd1, 2, 2);
        start_job(16'h0030, 16'd1, 16'd2, 16'd2);
        wait_done("t6_done", 60);
        check("t6_outs", 32'(out_cnt), 32'd4);
        step();
        step();
        check("t6_done_pulses", 32'(done_cnt), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
